// File: rtl/vga_fifo_fill_ctrl.sv
// Pixel-FIFO fill controller: bursts frame words from memory into the FIFO whenever it is below half full.
// Latency: the burst starts one edge after the request; fifo_wreq follows wb_ack_i with no delay. Backpressure: a burst starts only when fifo_hfull=0, and a bus error parks the block in ERR until ven drops.
// Optional sticky underrun detection is enabled by defining VGA_FILL_UNDERRUN_EN.
module vga_fifo_fill_ctrl #(
    parameter int AWIDTH    = 7,
    parameter int BURST_LEN = 16,
    parameter int FWIDTH    = 20
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              sclr,
    input  logic              ven,
    input  logic [29:0]       vbase,
    input  logic [FWIDTH-1:0] frame_words,
    input  logic              fifo_hfull,
    input  logic              fifo_empty,
    input  logic              pix_rreq,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [29:0]       wb_adr_o,
    output logic              fifo_wreq,
    output logic              fifo_sclr,
    output logic              frame_done,
    output logic              err_int,
    output logic              busy,
    output logic              underrun
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FWIDTH-1:0] wcnt_q, wcnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;
    logic              fifo_sclr_q, fifo_sclr_d;
    logic              ven_idle_q, ven_idle_d;

    logic wrap;
    logic last_beat;

    assign wrap      = (wcnt_q == (frame_words - FWIDTH'(1)));
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        beat_d       = beat_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        fifo_sclr_d  = 1'b0;
        ven_idle_d   = ven_idle_q;

        case (state_q)
            IDLE: begin
                beat_d     = '0;
                // ven is remembered only while idle, so a fall during a burst is acted on once the burst completes
                ven_idle_d = ven;
                if (!ven) begin
                    wcnt_d      = '0;
                    fifo_sclr_d = ven_idle_q;
                end
                if (ven && !fifo_hfull && !err_q) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (wb_err_i) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    beat_d  = '0;
                end else if (wb_ack_i) begin
                    if (wrap) begin
                        wcnt_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + FWIDTH'(1);
                    end
                    if (wrap || last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ERR: begin
                if (!ven) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sclr) begin
            state_d      = IDLE;
            wcnt_d       = '0;
            beat_d       = '0;
            err_d        = 1'b0;
            frame_done_d = 1'b0;
            fifo_sclr_d  = 1'b1;
            ven_idle_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            fifo_sclr_q  <= 1'b0;
            ven_idle_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            fifo_sclr_q  <= fifo_sclr_d;
            ven_idle_q   <= ven_idle_d;
        end
    end

    assign wb_cyc_o   = (state_q == BURST);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_adr_o   = vbase + 30'(wcnt_q);
    // An errored beat is never written even if ack arrives with it
    assign fifo_wreq  = wb_cyc_o & wb_ack_i & ~wb_err_i;
    assign fifo_sclr  = fifo_sclr_q;
    assign frame_done = frame_done_q;
    assign err_int    = err_q;
    assign busy       = (state_q != IDLE);

`ifdef VGA_FILL_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q | (pix_rreq & fifo_empty);
        if (sclr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    logic unused_monitor;
    assign unused_monitor = pix_rreq ^ fifo_empty;
    assign underrun       = 1'b0;
`endif

endmodule
